// File: rtl/rv_rr_priority_encoder_pkg.sv
// rv_arb_pkg: helpers shared by the round-robin arbiter family
package rv_arb_pkg;
  localparam int PTR_INIT_FWD = 0;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
  function automatic int popcount(input logic [63:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 64; i++) c += {31'b0, v[i]};
    return c;
  endfunction
  function automatic int ptr_init(input int n, input bit rev);
    return rev ? n - 1 : PTR_INIT_FWD;
  endfunction
endpackage

// File: rtl/rv_rr_priority_encoder_if.sv
// rv_rr_priority_encoder_if: request vector in, registered grant set out, valid/ready handshake
interface rv_rr_priority_encoder_if #(
  parameter int N      = 8,
  parameter int GRANTS = 2
);
  localparam int LN = rv_arb_pkg::clog2_min1(N);
  localparam int CW = $clog2(GRANTS + 1);
  logic [N-1:0]         req_in;
  logic                 ready_in;
  logic                 valid_out;
  logic [GRANTS-1:0]    grant_valid;
  logic [GRANTS*LN-1:0] index_out;
  logic [N-1:0]         onehot_out;
  logic [CW-1:0]        count_out;
  modport master (output req_in, ready_in, input valid_out, grant_valid, index_out, onehot_out, count_out);
  modport slave  (input req_in, ready_in, output valid_out, grant_valid, index_out, onehot_out, count_out);
endinterface

// File: rtl/rv_rr_priority_encoder_rotate_pick.sv
// rv_rotate_pick: first unmasked set request found walking from start, with wrap-around
module rv_rotate_pick #(
  parameter int N       = 8,
  parameter int LN      = 3,
  parameter int REVERSE = 0
) (
  input  logic [N-1:0]  req,
  input  logic [LN-1:0] start,
  input  logic [N-1:0]  mask,
  output logic [LN-1:0] idx,
  output logic [N-1:0]  onehot,
  output logic          found
);
  logic [N-1:0] avail;
  int p;
  assign avail = req & ~mask;
  always_comb begin
    idx = '0;
    found = 1'b0;
    p = 0;
    for (int i = 0; i < N; i++) begin
      p = (REVERSE != 0) ? (int'(start) - i + N) % N : (int'(start) + i) % N;
      if (!found && avail[p]) begin
        found = 1'b1;
        idx = LN'(p);
      end
    end
    onehot = found ? (N'(1) << idx) : '0;
  end
endmodule

// File: rtl/rv_rr_priority_encoder.sv
// rv_rr_priority_encoder: round-robin multi-grant encoder with a registered, back-pressured output
module rv_rr_priority_encoder
  import rv_arb_pkg::*;
#(
  parameter int N       = 8,
  parameter int GRANTS  = 2,
  parameter int REVERSE = 0
) (
  input logic clk,
  input logic reset,
  rv_rr_priority_encoder_if.slave bus
);
  localparam int LN = clog2_min1(N);
  localparam int CW = $clog2(GRANTS + 1);
  localparam logic [LN-1:0] PTR_RST = LN'(ptr_init(N, REVERSE != 0));
  logic [GRANTS:0][N-1:0]     mask;
  logic [GRANTS-1:0][LN-1:0]  pick_idx;
  logic [GRANTS-1:0][N-1:0]   pick_oh;
  logic [GRANTS-1:0]          found;
  logic [GRANTS*LN-1:0]       idx_pick;
  logic [LN-1:0]              last, ptr_adv;
  logic                       load;
  logic                       valid_q, valid_d;
  logic [GRANTS-1:0]          gv_q, gv_d;
  logic [GRANTS*LN-1:0]       idx_q, idx_d;
  logic [N-1:0]               oh_q, oh_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [LN-1:0]              ptr_q, ptr_d;
  assign mask[0] = '0;
  // each slot searches from the same pointer with earlier grants masked, so slots fill in encounter order
  for (genvar k = 0; k < GRANTS; k++) begin : g_slot
    rv_rotate_pick #(.N(N), .LN(LN), .REVERSE(REVERSE)) u_pick (
      .req    (bus.req_in),
      .start  (ptr_q),
      .mask   (mask[k]),
      .idx    (pick_idx[k]),
      .onehot (pick_oh[k]),
      .found  (found[k])
    );
    assign mask[k+1] = mask[k] | pick_oh[k];
  end
  always_comb begin
    load = ~valid_q | bus.ready_in;
    last = ptr_q;
    idx_pick = '0;
    for (int k = 0; k < GRANTS; k++) begin
      idx_pick[k*LN +: LN] = pick_idx[k];
      if (found[k]) last = pick_idx[k];
    end
    ptr_adv = (REVERSE != 0) ? ((last == '0) ? LN'(N - 1) : last - LN'(1))
                             : ((last == LN'(N - 1)) ? '0 : last + LN'(1));
    valid_d = load ? |bus.req_in : valid_q;
    gv_d    = load ? found : gv_q;
    idx_d   = load ? idx_pick : idx_q;
    oh_d    = load ? mask[GRANTS] : oh_q;
    cnt_d   = load ? CW'(popcount(64'(found))) : cnt_q;
    ptr_d   = (load && |bus.req_in) ? ptr_adv : ptr_q;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      gv_q    <= '0;
      idx_q   <= '0;
      oh_q    <= '0;
      cnt_q   <= '0;
      ptr_q   <= PTR_RST;
    end else begin
      valid_q <= valid_d;
      gv_q    <= gv_d;
      idx_q   <= idx_d;
      oh_q    <= oh_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end
  assign bus.valid_out   = valid_q;
  assign bus.grant_valid = gv_q;
  assign bus.index_out   = idx_q;
  assign bus.onehot_out  = oh_q;
  assign bus.count_out   = cnt_q;
endmodule

// File: doc/rv_rr_priority_encoder.md
Name: rv_rr_priority_encoder

Overview:
- Parametrised round-robin, multi-grant priority encoder with a registered output stage and a valid/ready handshake.
- Each accepted cycle selects up to GRANTS asserted request bits, searching from a rotating pointer, so that no requester is starved.
- Consumers are the warp/lane schedulers and the memory-request arbiters. They take the granted indices plus a combined one-hot mask.
- It is the sequential, fair successor to the combinational fixed-priority encoder.

Parameters:
- N, 8: number of request lines; legal range 2..64.
- GRANTS, 2: maximum simultaneous grants per accepted cycle; legal range 1..N.
- REVERSE, 0: 0 = search ascending from the pointer; 1 = search descending from the pointer.
- LN, derived ($clog2(N), minimum 1): index width. Not user-set.
- CW, derived ($clog2(GRANTS+1)): width of the grant count.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_in  in  N  request vector, sampled when the output stage is loadable.
- ready_in  in  1  downstream accepts the current output when valid_out=1.
- valid_out  out  1  output register holds at least one grant.
- grant_valid  out  GRANTS  bit k set = slot k holds a grant; bits are contiguous from bit 0.
- index_out  out  GRANTS*LN  slot k index in bits [k*LN +: LN]; slot 0 = first found from the pointer.
- onehot_out  out  N  OR of all granted bits.
- count_out  out  CW  number of set bits in grant_valid.

Behaviour:
- Reset (reset=0, async):
  - valid_out=0; grant_valid, index_out, onehot_out, count_out all 0.
  - Pointer ptr=0 when REVERSE=0; ptr=N-1 when REVERSE=1.
- Load condition: load = ~valid_out | ready_in.
- On each edge with load=1, the output register captures the combinational pick of req_in:
  - The pick walks the bits ptr, ptr±1, …, with wrap-around mod N.
  - The first GRANTS set bits fill slots 0..GRANTS-1 in encounter order.
  - valid_out <= |req_in.
- Latency: one cycle from req_in to valid_out. Throughput: one grant set per cycle while ready_in=1.
- Stall (valid_out=1, ready_in=0):
  - All outputs and ptr hold.
  - req_in is ignored. Withdrawn or new requests have no effect until load.
- Pointer update, on load with |req_in=1 only:
  - REVERSE=0: ptr <= (last granted index + 1) mod N.
  - REVERSE=1: ptr <= (last granted index - 1) mod N.
  - "Last granted" is the highest occupied slot.
- On load with req_in=0: valid_out <= 0, grant fields <= 0, ptr holds.
- Fewer set bits than GRANTS: only those slots are valid. Unused slots read index 0 with grant_valid bit 0.
- Full request with GRANTS=N: all N granted; ptr advances one full lap and returns to its previous value.
- Wrap: the search crosses N-1→0 (or 0→N-1 when REVERSE=1) seamlessly within a single cycle.
- Simultaneous accept and new request: the fire and the reload happen on the same edge, with no bubble.
- Reset mid-stall: held grants are discarded immediately (async). No grant is replayed after reset release.
- count_out always equals popcount(grant_valid); onehot_out always equals the OR of decode(index_out slot k) over the valid k.
- No X on any output after reset, including unused slots.

Decomposition:
- Shared package (rv_arb_pkg):
  - clog2-with-minimum-1 function;
  - popcount function;
  - localparam for the default pointer per REVERSE.
- Sub-module rv_rotate_pick (combinational):
  - Inputs: request vector, start pointer, mask of already-granted bits.
  - Outputs: first set index from the pointer, one-hot of that bit, found flag.
  - The top level chains GRANTS instances, each masking the previous grants.
- The top level owns the output register, the handshake and the pointer.

Test Plan:
- N=8, GRANTS=2, ptr=0, req_in=8'b1010_0110, ready_in=1:
  - next cycle valid_out=1, indices {1,2}, onehot_out=8'h06, count_out=2, ptr=3;
  - hold req_in → indices {5,7}, onehot_out=8'hA0, ptr wraps to 0.
- Stall: load {1,2}, drop ready_in for 3 cycles, change req_in to 8'h10 → outputs stay {1,2} and ptr stays 3; raise ready_in → next output index {4}, grant_valid=2'b01.
- Sparse request: req_in=8'h80, ptr=0 → grant_valid=2'b01, slot0=7, onehot_out=8'h80, count_out=1, ptr=0 (wrap).
- REVERSE=1, ptr=7, req_in=8'b0100_0011 → indices {6,1}, ptr=0; next cycle same req_in → indices {0,6}, ptr=5.
- Fairness: req_in=8'hFF held, GRANTS=1, ready_in=1 for 16 cycles → indices 0..7 twice in order; each requester granted exactly 2 times.
- Reset mid-stall: valid_out=1, ready_in=0, pull reset low mid-cycle → all outputs 0 before the next edge and ptr=0; after release, req_in=8'h08 → index 3.
